// File: rtl/bit8mem_word_writer.sv
`default_nettype none
// ============================================================================
//  Module   : bit8mem_word_writer
//  Purpose  : Serialises DATA_W-bit words from a valid/ready stream into
//             consecutive byte writes at an auto-incrementing byte address.
//  Options  : WR_BIG_ENDIAN_EN - when defined, the most significant byte of
//             each word goes to the lowest address (default little-endian).
//  Revision : 1.0 - initial release
// ============================================================================
module bit8mem_word_writer #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              load_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_writeE,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;

  logic                w_last_byte;
  logic [7:0]          w_cur_byte;
  logic [DATA_W-1:0]   w_shift_next;

`ifdef WR_BIG_ENDIAN_EN
  assign w_cur_byte   = shift_q[DATA_W-1 -: 8];
  assign w_shift_next = shift_q << 8;
`else
  assign w_cur_byte   = shift_q[7:0];
  assign w_shift_next = shift_q >> 8;
`endif

  assign w_last_byte = (state_q == S_WRITE) && (byte_idx_q == c_LAST_IDX);

  always_comb begin
    state_d      = state_q;
    addr_ptr_d   = addr_ptr_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_count_d = word_count_q;
    wr_ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending address load blocks acceptance so the word lands at the new pointer.
        wr_ready = !load_addr;
        if (load_addr) begin
          addr_ptr_d = start_addr;
        end else if (wr_valid) begin
          shift_d    = wr_data;
          byte_idx_d = '0;
          state_d    = S_WRITE;
        end
      end

      S_WRITE: begin
        addr_ptr_d = addr_ptr_q + 1'b1;
        shift_d    = w_shift_next;
        byte_idx_d = byte_idx_q + 1'b1;
        if (w_last_byte) begin
          wr_ready     = 1'b1;
          word_count_d = word_count_q + 1'b1;
          byte_idx_d   = '0;
          // Taking the next word on the last byte keeps the write strobe gap-free.
          if (wr_valid) begin
            shift_d = wr_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_ptr_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_ptr_q   <= addr_ptr_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_count_q <= word_count_d;
    end
  end

  assign mem_writeE = (state_q == S_WRITE);
  assign busy       = (state_q == S_WRITE);
  assign mem_addr   = addr_ptr_q;
  assign mem_wdata  = (state_q == S_WRITE) ? w_cur_byte : 8'h00;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bit8mem_word_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit8mem_word_writer
//  Purpose  : Directed self-checking bench for bit8mem_word_writer; honours
//             WR_BIG_ENDIAN_EN for the expected byte order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit8mem_word_writer;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;   // narrow counter so wrap is reachable quickly

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] start_addr;
  logic              load_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_writeE;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] words [0:3];

  bit8mem_word_writer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_addr(start_addr),
    .load_addr (load_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_writeE(mem_writeE),
    .busy      (busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int b);
`ifdef WR_BIG_ENDIAN_EN
    return w[8*(3-b) +: 8];
`else
    return w[8*b +: 8];
`endif
  endfunction

  // Streams words[0..n-1] starting from IDLE with wr_valid held, checking every byte.
  task automatic run_burst(input int n, input logic [ADDR_W-1:0] base, input bit pulse_load);
    logic [ADDR_W-1:0] a;
    load_addr = 1'b0;
    wr_data   = words[0];
    wr_valid  = 1'b1;
    #1 check("rdy_idle", 64'(wr_ready), 64'd1);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        a = base + ADDR_W'(4*k + b);
        check("we",    64'(mem_writeE), 64'd1);
        check("busy",  64'(busy),       64'd1);
        check("addr",  64'(mem_addr),   64'(a));
        check("data",  64'(mem_wdata),  64'(exp_byte(words[k], b)));
        check("rdy_wr", 64'(wr_ready),  (b == 3) ? 64'd1 : 64'd0);
        if (pulse_load && k == 0 && b == 1) begin
          load_addr  = 1'b1;
          start_addr = 27'd500;
        end
        if (pulse_load && b == 2) load_addr = 1'b0;
        if (b == 3) begin
          if (k + 1 < n) wr_data = words[k+1];
          else           wr_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_addr = '0; load_addr = 1'b0; wr_data = '0; wr_valid = 1'b0;
    tick(); tick();
    check("rst_rdy",  64'(wr_ready),   64'd1);
    check("rst_we",   64'(mem_writeE), 64'd0);
    check("rst_addr", 64'(mem_addr),   64'd0);
    check("rst_data", 64'(mem_wdata),  64'd0);
    check("rst_busy", 64'(busy),       64'd0);
    check("rst_wc",   64'(word_count), 64'd0);
    reset = 1'b0;
    tick();

    // Single word at address 22
    start_addr = 27'd22; load_addr = 1'b1;
    #1 check("rdy_load", 64'(wr_ready), 64'd0);
    tick();
    words[0] = 32'hA1B2C3D4;
    run_burst(1, 27'd22, 1'b0);
    tick();
    check("s1_we",  64'(mem_writeE), 64'd0);
    check("s1_rdy", 64'(wr_ready),   64'd1);
    check("s1_wc",  64'(word_count), 64'd1);

    // Three back-to-back words, counter wraps 3 -> 0
    words[0] = 32'h0A0B0C0D; words[1] = 32'h11121314; words[2] = 32'hF0E1D2C3;
    run_burst(3, 27'd26, 1'b0);
    tick();
    check("s2_we", 64'(mem_writeE), 64'd0);
    check("s2_wc", 64'(word_count), 64'd0);

    // Address wrap inside a word
    start_addr = 27'h7FFFFFE; load_addr = 1'b1;
    tick();
    words[0] = 32'h11223344;
    run_burst(1, 27'h7FFFFFE, 1'b0);
    tick();
    check("s3_wc", 64'(word_count), 64'd1);

    // Reset during byte 2 (pointer is at 2 after the wrap)
    words[0] = 32'h55667788;
    wr_data = words[0]; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    check("s4_addr_b2", 64'(mem_addr),  64'd4);
    check("s4_data_b2", 64'(mem_wdata), 64'(exp_byte(words[0], 2)));
    reset = 1'b1;
    tick();
    check("s4_we",   64'(mem_writeE), 64'd0);
    check("s4_busy", 64'(busy),       64'd0);
    check("s4_addr", 64'(mem_addr),   64'd0);
    check("s4_wc",   64'(word_count), 64'd0);
    reset = 1'b0;
    tick();
    words[0] = 32'hCAFEF00D;
    run_burst(1, 27'd0, 1'b0);
    tick();
    check("s4_wc2", 64'(word_count), 64'd1);

    // load_addr beats wr_valid in IDLE; load pulse during WRITE is ignored
    start_addr = 27'd100; load_addr = 1'b1; wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
    #1 check("s5_rdy", 64'(wr_ready), 64'd0);
    tick();
    check("s5_we1", 64'(mem_writeE), 64'd0);
    tick();
    check("s5_we2", 64'(mem_writeE), 64'd0);
    words[0] = 32'hDEADBEEF; words[1] = 32'h01234567;
    run_burst(2, 27'd100, 1'b1);
    tick();
    check("s5_we", 64'(mem_writeE), 64'd0);
    check("s5_wc", 64'(word_count), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
